bias_relu_pool: RTL and testbench

- Downstream stage of the layer-2 convolution engine.
- Captures each stored adder-tree result for the current output channel, adds the channel bias, saturates and applies ReLU, then buffers the value into a local H x W feature tile.
- On the pool command it performs 2x2 stride-2 max pooling over the tile and writes (H/2)*(W/2) bytes to the pooled-feature memory at a channel-indexed offset.
- It then returns pool_done to the layer controller.

---
 rtl/bias_relu_pool.sv | 143 ++++++++++++++
 tb/tb_bias_relu_pool.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bias_relu_pool.sv
// rtl/bias_relu_pool.sv - bias add, saturating ReLU, tile buffer and 2x2 stride-2 pooling
// Optional BIAS_RELU_POOL_AVG_EN: average pooling instead of max pooling.
module bias_relu_pool #(
    parameter int H        = 12,
    parameter int W        = 12,
    parameter int ADDR_LEN = 7,
    parameter int OUT_AW   = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     store,
    input  logic [ADDR_LEN:0]        address,
    input  logic signed [7:0]        result,
    input  logic signed [7:0]        bias,
    input  logic [3:0]               out_c,
    input  logic                     pool,
    output logic                     pool_done,
    output logic                     busy,
    output logic                     out_we,
    output logic [OUT_AW-1:0]        out_addr,
    output logic [7:0]               out_data,
    output logic                     overrun
);
    localparam int HP = H / 2;
    localparam int WP = W / 2;
    localparam int NT = H * W;
    localparam int NW = HP * WP;
    localparam int AW = ADDR_LEN + 1;
    localparam int RW = (HP > 1) ? $clog2(HP) : 1;
    localparam int CW = (WP > 1) ? $clog2(WP) : 1;

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    state_t state, state_nx;

    logic [RW-1:0]     wr;
    logic [CW-1:0]     wc;
    logic [1:0]        k;
    logic [3:0]        oc;
    logic [7:0]        tile [NT];
    logic [AW-1:0]     tap_idx;
    logic [7:0]        tap;
    logic [7:0]        pool_val;
    logic signed [8:0] sum9;
    logic [7:0]        relu;
    logic              last_win;
    logic [OUT_AW-1:0] addr_calc;

`ifdef BIAS_RELU_POOL_AVG_EN
    logic [9:0] acc, acc_nx;
`else
    logic [7:0] acc, acc_nx;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pool) state_nx = RD;
            RD:      if (k == 2'd3) state_nx = WR;
            WR:      state_nx = last_win ? DONE : RD;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign out_we    = (state == WR);
    assign pool_done = (state == DONE);
    assign last_win  = (wr == RW'(HP - 1)) && (wc == CW'(WP - 1));

    // 9-bit sum cannot overflow; clamp high to 127, negatives collapse to 0
    always_comb begin
        sum9 = {result[7], result} + {bias[7], bias};
        if (sum9[8])               relu = 8'd0;
        else if (sum9 > 9'sd127)   relu = 8'd127;
        else                       relu = sum9[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst && state == IDLE && store && int'(address) < NT)
            tile[address] <= relu;
    end

    always_comb begin
        tap_idx = AW'((2 * int'(wr) + int'(k[1])) * W + 2 * int'(wc) + int'(k[0]));
        tap     = tile[tap_idx];
`ifdef BIAS_RELU_POOL_AVG_EN
        acc_nx   = (k == 2'd0) ? {2'b00, tap} : acc + {2'b00, tap};
        pool_val = acc_nx[9:2];
`else
        acc_nx   = (k == 2'd0 || tap > acc) ? tap : acc;
        pool_val = acc_nx;
`endif
        addr_calc = OUT_AW'(oc) * OUT_AW'(NW) + OUT_AW'(wr) * OUT_AW'(WP) + OUT_AW'(wc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr       <= '0;
            wc       <= '0;
            k        <= '0;
            acc      <= '0;
            oc       <= '0;
            out_addr <= '0;
            out_data <= '0;
            overrun  <= 1'b0;
        end else begin
            if (store && state != IDLE) overrun <= 1'b1;
            case (state)
                IDLE: if (pool) begin
                    wr  <= '0;
                    wc  <= '0;
                    k   <= '0;
                    acc <= '0;
                    oc  <= out_c;
                end
                RD: begin
                    acc <= acc_nx;
                    k   <= k + 2'd1;
                    // result registered on the last tap so it is stable throughout WR
                    if (k == 2'd3) begin
                        out_data <= pool_val;
                        out_addr <= addr_calc;
                    end
                end
                WR: begin
                    k <= '0;
                    if (wc == CW'(WP - 1)) begin
                        wc <= '0;
                        wr <= wr + 1'b1;
                    end else begin
                        wc <= wc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bias_relu_pool.sv
// tb/tb_bias_relu_pool.sv - directed self-checking bench for bias_relu_pool
// Expected pooled values follow BIAS_RELU_POOL_AVG_EN when defined.
module tb_bias_relu_pool;
    logic              clk = 1'b0;
    logic              rst, store, pool;
    logic [7:0]        address;
    logic signed [7:0] result, bias;
    logic [3:0]        out_c;
    logic              pool_done, busy, out_we, overrun;
    logic [9:0]        out_addr;
    logic [7:0]        out_data;

    int checks = 0;
    int failures = 0;
    int wcount = 0;
    int dcount = 0;
    logic [9:0] log_addr [0:1023];
    logic [7:0] log_data [0:1023];

    bias_relu_pool dut (
        .clk(clk), .rst(rst), .store(store), .address(address), .result(result),
        .bias(bias), .out_c(out_c), .pool(pool), .pool_done(pool_done), .busy(busy),
        .out_we(out_we), .out_addr(out_addr), .out_data(out_data), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (out_we === 1'b1 && wcount < 1024) begin
            log_addr[wcount] <= out_addr;
            log_data[wcount] <= out_data;
            wcount <= wcount + 1;
        end
        if (pool_done === 1'b1) dcount <= dcount + 1;
    end

    function automatic int expw(input int a, input int b, input int c, input int d);
`ifdef BIAS_RELU_POOL_AVG_EN
        return (a + b + c + d) / 4;
`else
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic put(input int a, input int r, input int b);
        store   = 1'b1;
        address = 8'(a);
        result  = 8'(r);
        bias    = 8'(b);
        @(negedge clk);
    endtask

    task automatic idle_n(input int n);
        store = 1'b0;
        pool  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            pool  = 1'b0;
            store = 1'b0;
            cyc++;
            if (pool_done === 1'b1) break;
        end
        check("pool_done_seen", 32'(pool_done), 1);
        check("busy_at_done", 32'(busy), 1);
    endtask

    task automatic run_pool(input int oc, output int cyc);
        out_c = 4'(oc);
        pool  = 1'b1;
        wait_done(cyc);
    endtask

    initial begin
        int base, cyc, bad, d0, wr, wc, t0;
        rst = 1'b1; store = 1'b0; pool = 1'b0; address = '0;
        result = '0; bias = '0; out_c = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset state and quiet idle
        check("rst_pool_done", 32'(pool_done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_out_we", 32'(out_we), 0);
        check("rst_out_addr", 32'(out_addr), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_overrun", 32'(overrun), 0);
        idle_n(10);
        check("idle_no_writes", 32'(wcount), 0);

        // bias / saturation / ReLU plus two tap patterns
        for (int i = 0; i < 144; i++) put(i, 0, 0);
        put(0, 100, 50);
        put(2, -20, 10);
        put(4, -128, -128);
        put(6, 30, -5);
        put(8, 1, 0); put(9, 2, 0); put(20, 3, 0); put(21, 6, 0);
        put(10, 127, 0); put(11, 127, 0); put(22, 127, 0); put(23, 127, 0);
        idle_n(1);
        base = wcount;
        run_pool(0, cyc);
        idle_n(2);
        check("sat_high", 32'(log_data[base + 0]), expw(127, 0, 0, 0));
        check("relu_neg", 32'(log_data[base + 1]), 0);
        check("sat_low", 32'(log_data[base + 2]), 0);
        check("bias_neg", 32'(log_data[base + 3]), expw(25, 0, 0, 0));
        check("taps_1236", 32'(log_data[base + 4]), expw(1, 2, 3, 6));
        check("taps_127x4", 32'(log_data[base + 5]), 127);
        check("win5_addr", 32'(log_addr[base + 5]), 5);

        // full channel, out_c = 3
        for (int i = 0; i < 144; i++) put(i, i % 128, 0);
        idle_n(1);
        base = wcount;
        run_pool(3, cyc);
        check("latency", 32'(cyc), 181);
        idle_n(2);
        check("full_writes", 32'(wcount - base), 36);
        check("full_first_addr", 32'(log_addr[base]), 108);
        check("full_last_addr", 32'(log_addr[base + 35]), 143);
        check("full_win0", 32'(log_data[base]), expw(0, 1, 12, 13));
        check("full_win35", 32'(log_data[base + 35]), expw(2, 3, 14, 15));
        bad = 0;
        for (int n = 0; n < 36; n++) begin
            wr = n / 6; wc = n % 6; t0 = 24 * wr + 2 * wc;
            if (log_addr[base + n] !== 10'(108 + n) ||
                log_data[base + n] !== 8'(expw(t0 % 128, (t0 + 1) % 128,
                                               (t0 + 12) % 128, (t0 + 13) % 128)))
                bad++;
        end
        check("full_windows_bad", 32'(bad), 0);

        // pool while busy is ignored; store during RD flags overrun and is dropped
        base = wcount; d0 = dcount;
        out_c = 4'd3;
        pool = 1'b1;
        @(negedge clk);
        pool = 1'b0;
        @(negedge clk);
        pool = 1'b1; store = 1'b1; address = 8'd13; result = 8'sd100; bias = 8'sd0;
        wait_done(cyc);
        check("overrun_set", 32'(overrun), 1);
        idle_n(200);
        check("busy_pool_single_done", 32'(dcount - d0), 1);
        check("busy_pool_writes", 32'(wcount - base), 36);
        base = wcount;
        run_pool(3, cyc);
        idle_n(2);
        check("tile_unchanged", 32'(log_data[base]), expw(0, 1, 12, 13));

        // store and pool in the same IDLE cycle
        store = 1'b1; address = 8'd0; result = 8'sd90; bias = 8'sd0;
        base = wcount;
        run_pool(3, cyc);
        idle_n(2);
        check("same_cycle_store", 32'(log_data[base]), expw(90, 1, 12, 13));

        // reset in the middle of a pass
        base = wcount; d0 = dcount;
        out_c = 4'd3;
        pool = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            pool = 1'b0;
            if (wcount - base >= 10) break;
        end
        check("midpass_reached", 32'(wcount - base), 10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", 32'(busy), 0);
        check("midrst_out_we", 32'(out_we), 0);
        check("midrst_pool_done", 32'(pool_done), 0);
        check("midrst_overrun", 32'(overrun), 0);
        idle_n(200);
        check("midrst_no_writes", 32'(wcount - base), 10);
        check("midrst_no_done", 32'(dcount - d0), 0);
        base = wcount;
        run_pool(2, cyc);
        idle_n(2);
        check("fresh_writes", 32'(wcount - base), 36);
        check("fresh_first_addr", 32'(log_addr[base]), 72);
        check("fresh_last_addr", 32'(log_addr[base + 35]), 107);
        check("fresh_tile_kept", 32'(log_data[base]), expw(90, 1, 12, 13));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
